// File: rtl/vsync_frame_sequencer.sv
// rtl/vsync_frame_sequencer.sv - vertical SYNC/BACK/ACTIVE/FRONT sequencer driven by LineEnd edges
// Optional macro VSYNC_SEQ_SHADOW_EN: phase lengths are shadowed once per frame.
module vsync_frame_sequencer #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             LineEnd,
  input  logic [WIDTH-1:0] SynchPulse,
  input  logic [WIDTH-1:0] BackPorch,
  input  logic [WIDTH-1:0] ActiveVideo,
  input  logic [WIDTH-1:0] FrontPorch,
  output logic             vsync,
  output logic             v_active,
  output logic [WIDTH-1:0] yposition,
  output logic             FrameEnd
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BACK   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FRONT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lcnt_q, lcnt_d;
  logic [WIDTH-1:0] ypos_q, ypos_d;
  logic             line_end_q;
  logic             vsync_q, vsync_d;
  logic             v_active_q, v_active_d;
  logic             frame_end_q, frame_end_d;
  logic [WIDTH-1:0] sync_len, back_len, active_len, front_len;
  logic [WIDTH-1:0] raw_len, len_c;
  logic             line_evt, last_line;

`ifdef VSYNC_SEQ_SHADOW_EN
  logic [WIDTH-1:0] sync_sh_q, back_sh_q, active_sh_q, front_sh_q;
  logic             sh_valid_q;

  // Until the first capture lands, the live inputs stand in for the shadows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_sh_q   <= '0;
      back_sh_q   <= '0;
      active_sh_q <= '0;
      front_sh_q  <= '0;
      sh_valid_q  <= 1'b0;
    end else if (!sh_valid_q || frame_end_q) begin
      sync_sh_q   <= SynchPulse;
      back_sh_q   <= BackPorch;
      active_sh_q <= ActiveVideo;
      front_sh_q  <= FrontPorch;
      sh_valid_q  <= 1'b1;
    end
  end

  assign sync_len   = sh_valid_q ? sync_sh_q   : SynchPulse;
  assign back_len   = sh_valid_q ? back_sh_q   : BackPorch;
  assign active_len = sh_valid_q ? active_sh_q : ActiveVideo;
  assign front_len  = sh_valid_q ? front_sh_q  : FrontPorch;
`else
  assign sync_len   = SynchPulse;
  assign back_len   = BackPorch;
  assign active_len = ActiveVideo;
  assign front_len  = FrontPorch;
`endif

  assign line_evt = LineEnd & ~line_end_q;

  always_comb begin
    raw_len = sync_len;
    case (state_q)
      ST_SYNC:   raw_len = sync_len;
      ST_BACK:   raw_len = back_len;
      ST_ACTIVE: raw_len = active_len;
      ST_FRONT:  raw_len = front_len;
      default:   raw_len = sync_len;
    endcase
  end

  // Zero length is clamped to one line so the len-1 compare cannot underflow.
  assign len_c     = (raw_len == '0) ? WIDTH'(1) : raw_len;
  assign last_line = (lcnt_q == (len_c - WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    frame_end_d = 1'b0;
    if (line_evt) begin
      if (last_line) begin
        lcnt_d = '0;
        case (state_q)
          ST_SYNC:   state_d = ST_BACK;
          ST_BACK:   state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_FRONT;
          ST_FRONT: begin
            state_d     = ST_SYNC;
            frame_end_d = 1'b1;
          end
          default:   state_d = ST_SYNC;
        endcase
      end else begin
        lcnt_d = lcnt_q + WIDTH'(1);
      end
    end
    vsync_d    = (state_d != ST_SYNC);
    v_active_d = (state_d == ST_ACTIVE);
    ypos_d     = (state_d == ST_ACTIVE) ? lcnt_d : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      lcnt_q      <= '0;
      line_end_q  <= 1'b0;
      vsync_q     <= 1'b0;
      v_active_q  <= 1'b0;
      ypos_q      <= '0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      line_end_q  <= LineEnd;
      vsync_q     <= vsync_d;
      v_active_q  <= v_active_d;
      ypos_q      <= ypos_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign vsync     = vsync_q;
  assign v_active  = v_active_q;
  assign yposition = ypos_q;
  assign FrameEnd  = frame_end_q;

endmodule

// File: tb/tb_vsync_frame_sequencer.sv
// tb/tb_vsync_frame_sequencer.sv - randomized self-checking bench for vsync_frame_sequencer
// Reference model tracks the line index within the frame and derives the phase arithmetically.
module tb_vsync_frame_sequencer;
  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         LineEnd = 1'b0;
  logic [W-1:0] SynchPulse = '0, BackPorch = '0, ActiveVideo = '0, FrontPorch = '0;
  logic         vsync, v_active, FrameEnd;
  logic [W-1:0] yposition;

  int vectors = 0;
  int miscompares = 0;

  int           k, fs, fb, fa, ff;
  logic         m_le_q;
  logic         exp_vs, exp_va, exp_fe;
  logic [W-1:0] exp_y;

  always #5 clock = ~clock;

  vsync_frame_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .LineEnd(LineEnd),
    .SynchPulse(SynchPulse), .BackPorch(BackPorch),
    .ActiveVideo(ActiveVideo), .FrontPorch(FrontPorch),
    .vsync(vsync), .v_active(v_active), .yposition(yposition), .FrameEnd(FrameEnd)
  );

  task automatic set_lengths(input int s, input int b, input int a, input int f);
    SynchPulse = W'(s); BackPorch = W'(b); ActiveVideo = W'(a); FrontPorch = W'(f);
  endtask

  task automatic latch_lengths();
    fs = (SynchPulse == 0)  ? 1 : int'(SynchPulse);
    fb = (BackPorch == 0)   ? 1 : int'(BackPorch);
    fa = (ActiveVideo == 0) ? 1 : int'(ActiveVideo);
    ff = (FrontPorch == 0)  ? 1 : int'(FrontPorch);
  endtask

  task automatic model_reset();
    k = 0; m_le_q = 1'b0;
    exp_vs = 1'b0; exp_va = 1'b0; exp_y = '0; exp_fe = 1'b0;
    latch_lengths();
  endtask

  // Frame = fs+fb+fa+ff lines; k is the line index inside it, advanced once per rising LineEnd.
  task automatic model_step(input logic le);
    logic ev;
`ifndef VSYNC_SEQ_SHADOW_EN
    latch_lengths();
`endif
    ev = le & ~m_le_q;
    m_le_q = le;
    exp_fe = 1'b0;
    if (ev) begin
      k++;
      if (k >= fs + fb + fa + ff) begin
        k = 0;
        exp_fe = 1'b1;
`ifdef VSYNC_SEQ_SHADOW_EN
        latch_lengths();
`endif
      end
    end
    exp_vs = (k >= fs);
    exp_va = (k >= fs + fb) && (k < fs + fb + fa);
    exp_y  = exp_va ? W'(k - fs - fb) : '0;
  endtask

  task automatic clk_cycle(input logic le);
    LineEnd = le;
    @(posedge clock);
    model_step(le);
    @(negedge clock);
  endtask

  task automatic do_reset(input int n, input logic le_rel);
    reset = 1'b1; LineEnd = 1'b0;
    repeat (n) @(negedge clock);
    model_reset();
    LineEnd = le_rel;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_lengths(2, 3, 5, 2);
    reset = 1'b1; LineEnd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      vectors++;
      if ({vsync, v_active, yposition, FrameEnd} !== {1'b0, 1'b0, W'(0), 1'b0}) begin
        miscompares++;
        $display("FAIL reset: got vs=%b va=%b y=%0d fe=%b, expected all zero", vsync, v_active, yposition, FrameEnd);
      end
    end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    int fe_cnt = 0;
    for (int i = 0; i < 288; i++) begin
      clk_cycle((i % 8) == 0);
      if (FrameEnd === 1'b1) fe_cnt++;
      vectors++;
      if ({vsync, v_active, yposition, FrameEnd} !== {exp_vs, exp_va, exp_y, exp_fe}) begin
        miscompares++;
        $display("FAIL basic t=%0t: got vs=%b va=%b y=%0d fe=%b, expected vs=%b va=%b y=%0d fe=%b", $time, vsync, v_active, yposition, FrameEnd, exp_vs, exp_va, exp_y, exp_fe);
      end
    end
    vectors++;
    if (fe_cnt != 3) begin
      miscompares++;
      $display("FAIL basic_frame_count: got %0d FrameEnd pulses, expected 3", fe_cnt);
    end
  endtask

  task automatic test_held_lineend();
    int guard = 0;
    while (k != fs && guard < 100) begin
      clk_cycle(1'b1);
      clk_cycle(1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL held_reach_back: got no BACK phase within 100 lines, expected BACK");
    end
    for (int i = 0; i < 60; i++) begin
      clk_cycle((i < 20) || (i >= 22 && (i % 2) == 0));
      vectors++;
      if ({vsync, v_active, yposition, FrameEnd} !== {exp_vs, exp_va, exp_y, exp_fe}) begin
        miscompares++;
        $display("FAIL held t=%0t: got vs=%b va=%b y=%0d fe=%b, expected vs=%b va=%b y=%0d fe=%b", $time, vsync, v_active, yposition, FrameEnd, exp_vs, exp_va, exp_y, exp_fe);
      end
    end
  endtask

  task automatic test_zero_length();
    int   ev_since = 0;
    logic prev = 1'b0;
    logic le;
    set_lengths(2, 0, 5, 2);
    do_reset(3, 1'b0);
    for (int i = 0; i < 200; i++) begin
      le = ((i % 4) == 0) || ((i % 4) == 1 && (i % 3) == 0);
      clk_cycle(le);
      if (le && !prev) ev_since++;
      prev = le;
      vectors++;
      if ({vsync, v_active, yposition, FrameEnd} !== {exp_vs, exp_va, exp_y, exp_fe}) begin
        miscompares++;
        $display("FAIL zero_len t=%0t: got vs=%b va=%b y=%0d fe=%b, expected vs=%b va=%b y=%0d fe=%b", $time, vsync, v_active, yposition, FrameEnd, exp_vs, exp_va, exp_y, exp_fe);
      end
      if (FrameEnd === 1'b1) begin
        vectors++;
        if (ev_since != 10) begin
          miscompares++;
          $display("FAIL zero_len_frame: got %0d lines per frame, expected 10", ev_since);
        end
        ev_since = 0;
      end
    end
  endtask

  task automatic test_reset_mid_active();
    int guard = 0;
    set_lengths(2, 3, 5, 2);
    do_reset(2, 1'b0);
    while (!(v_active === 1'b1 && yposition == 3) && guard < 100) begin
      clk_cycle(1'b1);
      clk_cycle(1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL mid_reach_y3: got y=%0d va=%b after 100 lines, expected y=3 active", yposition, v_active);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({vsync, v_active, yposition, FrameEnd} !== {1'b0, 1'b0, W'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL mid_async_reset: got vs=%b va=%b y=%0d fe=%b, expected all zero", vsync, v_active, yposition, FrameEnd);
    end
    do_reset(2, 1'b0);
    for (int i = 0; i < 60; i++) begin
      clk_cycle((i % 3) == 0);
      vectors++;
      if ({vsync, v_active, yposition, FrameEnd} !== {exp_vs, exp_va, exp_y, exp_fe}) begin
        miscompares++;
        $display("FAIL mid_restart t=%0t: got vs=%b va=%b y=%0d fe=%b, expected vs=%b va=%b y=%0d fe=%b", $time, vsync, v_active, yposition, FrameEnd, exp_vs, exp_va, exp_y, exp_fe);
      end
    end
  endtask

  task automatic test_shadow();
    int guard = 0;
    int maxy = 1;
    int n = 0;
    int act_len[2];
    int exp_first;
`ifdef VSYNC_SEQ_SHADOW_EN
    exp_first = 5;
`else
    exp_first = 8;
`endif
    act_len[0] = 0; act_len[1] = 0;
    set_lengths(2, 3, 5, 2);
    do_reset(2, 1'b0);
    while (!(v_active === 1'b1 && yposition == 1) && guard < 100) begin
      clk_cycle(1'b1);
      clk_cycle(1'b0);
      guard++;
    end
    ActiveVideo = W'(8);
    guard = 0;
    while (n < 2 && guard < 400) begin
      clk_cycle((guard % 2) == 0);
      guard++;
      vectors++;
      if ({vsync, v_active, yposition, FrameEnd} !== {exp_vs, exp_va, exp_y, exp_fe}) begin
        miscompares++;
        $display("FAIL shadow t=%0t: got vs=%b va=%b y=%0d fe=%b, expected vs=%b va=%b y=%0d fe=%b", $time, vsync, v_active, yposition, FrameEnd, exp_vs, exp_va, exp_y, exp_fe);
      end
      if (v_active === 1'b1 && int'(yposition) > maxy) maxy = int'(yposition);
      if (FrameEnd === 1'b1) begin
        act_len[n] = maxy + 1;
        maxy = -1;
        n++;
      end
    end
    vectors++;
    if (act_len[0] != exp_first) begin
      miscompares++;
      $display("FAIL shadow_cur_active: got %0d lines, expected %0d", act_len[0], exp_first);
    end
    vectors++;
    if (act_len[1] != 8) begin
      miscompares++;
      $display("FAIL shadow_next_active: got %0d lines, expected 8", act_len[1]);
    end
  endtask

  task automatic test_random();
    logic le;
    int   left;
    for (int it = 0; it < 4; it++) begin
      set_lengths($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      le = ((it % 2) == 1);
      do_reset(3, le);
      left = $urandom_range(1, 3);
      for (int c = 0; c < 500; c++) begin
        clk_cycle(le);
        vectors++;
        if ({vsync, v_active, yposition, FrameEnd} !== {exp_vs, exp_va, exp_y, exp_fe}) begin
          miscompares++;
          $display("FAIL random it=%0d t=%0t: got vs=%b va=%b y=%0d fe=%b, expected vs=%b va=%b y=%0d fe=%b", it, $time, vsync, v_active, yposition, FrameEnd, exp_vs, exp_va, exp_y, exp_fe);
        end
        left--;
        if (left == 0) begin
          le = ~le;
          left = $urandom_range(1, 3);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_held_lineend();
    test_zero_length();
    test_reset_mid_active();
    test_shadow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vsync_frame_sequencer.md
# vsync_frame_sequencer

Vertical timing controller that sequences the display frame line-by-line from the horizontal timing block's `LineEnd` output. It walks a four-phase frame (sync, back porch, active, front porch) and drives `vsync`, the vertical position and the vertical-active qualifier. It also emits a one-clock frame-boundary strobe. It sits beside the hsync module in the video timing path and feeds the pixel/pong renderer.

## Interface
Parameters:
- `WIDTH`, 10, width of line counts and `yposition`

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `LineEnd`  in  1  end-of-line indicator from hsync block; level or pulse, any length ≥1 clock
- `SynchPulse`  in  WIDTH  vsync pulse length, in lines
- `BackPorch`  in  WIDTH  back-porch length, in lines
- `ActiveVideo`  in  WIDTH  active-video length, in lines
- `FrontPorch`  in  WIDTH  front-porch length, in lines
- `vsync`  out  1  active-low vertical sync
- `v_active`  out  1  high during ACTIVE phase
- `yposition`  out  WIDTH  active line index, 0..ActiveVideo-1
- `FrameEnd`  out  1  one-clock strobe at frame wrap

## Operation
- Line event: `line_evt = LineEnd & ~LineEnd_q`, where `LineEnd_q` is `LineEnd` registered. Exactly one event per rising edge of `LineEnd`. A held-high `LineEnd` produces no further events.
- State machine with states SYNC → BACK → ACTIVE → FRONT → SYNC, and a line counter `lcnt`.
- Phase length `len` is the active phase's length input. A length of 0 is treated as 1, so every phase lasts at least one line.
- On `line_evt`:
  - if `lcnt == len-1`, set `lcnt` to 0 and advance the state;
  - otherwise, increment `lcnt`.
- No state or counter change without `line_evt`.
- `vsync` = 0 in SYNC and 1 otherwise.
- `v_active` = 1 in ACTIVE.
- `yposition`:
  - equals `lcnt` while in ACTIVE;
  - holds 0 in all other states.
- `FrameEnd`: pulses for one clock on the edge where FRONT → SYNC is taken.
- All outputs are registered.
- Arithmetic is unsigned WIDTH bits. The `len-1` compare uses the clamped length and never underflows.

## Timing
- Reset values: state = SYNC, `lcnt` = 0, `vsync` = 0, `v_active` = 0, `yposition` = 0, `FrameEnd` = 0, `LineEnd_q` = 0.
- Reset is asynchronous. Asserting it mid-frame forces reset values immediately.
- After `reset` deasserts, the first frame starts in SYNC at line 0.
- Latency: outputs change on the clock edge where `LineEnd` is first sampled high and `LineEnd_q` is still 0. They are visible one clock after `LineEnd` rises.
- Frame length = sum of the clamped phase lengths, in line events.
- `LineEnd` high at reset release: `LineEnd_q` = 0, so an event fires on the first clock.
- A `LineEnd` asserted and deasserted between two clock edges is not seen. The caller must hold it ≥1 clock.

## Configuration
- `VSYNC_SEQ_SHADOW_EN` defined:
  - The four length inputs are captured into shadow registers on the first clock after reset release.
  - They are recaptured on every clock where `FrameEnd` is asserted.
  - All phase decisions use the shadow values, so mid-frame input changes take effect only at the next frame.
- Not defined:
  - Phase decisions use the live inputs.
  - A mid-phase change to the current phase length takes effect at the next `line_evt` compare.
  - If the new length is ≤ `lcnt`, the phase runs until `lcnt` wraps at 2^WIDTH-1. Software must not do this.

## Test plan
- Reset and basic frame:
  - Lengths 2/3/5/2, `LineEnd` pulsed 1 clock every 8 clocks, reset high for 12 clocks.
  - Required: `vsync` low for exactly 2 lines, then high for 10.
  - Required: `v_active` high for 5 lines with `yposition` 0,1,2,3,4.
  - Required: `FrameEnd` pulses once every 12 line events.
- Held `LineEnd`:
  - Hold `LineEnd` high for 20 clocks in the BACK phase.
  - Required: exactly one line event; `lcnt` advances by 1 only.
- Zero length:
  - BackPorch = 0, other lengths 2/5/2.
  - Required: BACK lasts 1 line; frame = 10 lines.
- Reset mid-ACTIVE:
  - Assert `reset` asynchronously at `yposition` = 3.
  - Required: `vsync` = 0, `v_active` = 0, `yposition` = 0 immediately, without waiting for a clock edge.
  - Required: the next frame restarts from SYNC line 0.
- Shadowing (`VSYNC_SEQ_SHADOW_EN`):
  - Change ActiveVideo 5 → 8 during ACTIVE line 1.
  - Required: the current frame's active phase is 5 lines and the next frame's is 8.
  - Without the macro: the current frame's active phase is 8 lines.
